pipelined_shifter: RTL and testbench
====================================

# pipelined_shifter

Parametrised, pipelined barrel shifter for the execute datapath: shifts or rotates a WIDTH-bit operand by a log2(WIDTH)-bit amount in one of four modes. It is built as log2(WIDTH) registered stages with a valid/ready handshake on both sides, so long shifts no longer sit in a single combinational path. It replaces the fixed 8-bit, left-only, combinational shifter in the ALU shift path and also produces a registered zero flag for the flag unit.

## Interface
- WIDTH, 16, operand width; must be a power of two, at least 2.
- SHW (localparam), log2(WIDTH), shift-amount width and stage count.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush; discards all in-flight operations.
- in_valid  input  1  an operation is offered on in_*.
- in_ready  output  1  the shifter accepts the offered operation on this cycle.
- in_data  input  WIDTH  operand to shift.
- in_shamt  input  SHW  shift amount, 0..WIDTH-1.
- in_mode  input  2  operation: 00 SLL, 01 SRA, 10 ROR, 11 SRL.
- out_valid  output  1  out_data and out_zero hold a completed result.
- out_ready  input  1  the consumer takes the result on this cycle.
- out_data  output  WIDTH  shifted or rotated result.
- out_zero  output  1  1 when out_data == 0; belongs to the same result.

## Operation
- Stage k (k = 0..SHW-1) holds a registered word, the remaining shamt bits, the mode, and a valid bit.
- Stage k applies a shift by 2^(SHW-1-k) when that bit of the shift amount is set; the most significant bit is processed first. Otherwise it passes the word through unchanged.
- The last stage drives out_data and out_valid directly.
- Fill rules per mode:
  - SLL: fill with 0 at the LSB end.
  - SRL: fill with 0 at the MSB end.
  - SRA: fill with the sign bit of the original operand at the MSB end.
  - ROR: bits shifted out of the LSB end re-enter at the MSB end.
- in_shamt = 0 gives out_data = in_data in every mode. Amounts are always taken modulo WIDTH by construction.
- out_zero is computed from the final-stage word and registered alongside it.
- Advance rule: adv = !out_valid || out_ready. When adv = 1, every stage loads from its predecessor. Stage 0 loads in_valid and the in_* fields.
- When adv = 0, all stages hold. Bubbles are not collapsed.
- in_ready = adv && !flush. An operation is accepted only when in_valid && in_ready.
- Flush: on the next edge all valid bits clear. Data registers may keep stale values. Flush has priority over advance and over accept.
- Operations leave in acceptance order. Each accepted operation produces exactly one result; none are dropped or duplicated unless flush is asserted.

## Timing
- Reset (rst_n low, asynchronous): all valid bits clear; out_valid = 0, out_data = 0, out_zero = 0.
- After reset release: in_ready = 1 on the first cycle.
- Latency: an operation accepted at edge N is presented with out_valid = 1 after edge N+SHW-1, i.e. SHW cycles after acceptance, provided there is no stall. This is 4 cycles at WIDTH = 16.
- Throughput: one operation per cycle while out_ready stays high.
- Backpressure: when out_valid = 1 and out_ready = 0:
  - out_data, out_zero and out_valid hold stable;
  - in_ready = 0 in the same cycle (combinational from out_ready).
- Simultaneous handshakes: out_ready && in_valid in the same cycle retires one result and accepts one operation on that edge.
- Reset mid-operation: all in-flight operations are lost. No output appears until new operations are accepted.
- Flush together with out_ready = 1: the visible result is not counted as consumed; it is simply discarded.

## Test plan
- Basic modes, WIDTH = 16, out_ready = 1:
  - SLL 0x0001 by 15 -> out_data 0x8000, out_zero 0;
  - SRA 0x8000 by 15 -> 0xFFFF;
  - SRL 0x8000 by 4 -> 0x0800;
  - ROR 0x0001 by 1 -> 0x8000;
  - each result appears exactly 4 cycles after acceptance.
- Zero and identity:
  - SLL 0x8000 by 1 -> 0x0000 with out_zero 1;
  - SRA 0x1234 by 0 -> 0x1234 with out_zero 0.
- Streaming: send 8 back-to-back operations with random data, shamt and mode -> 8 results in order, one per cycle, every one matching the reference model.
- Backpressure:
  - hold out_ready low for 5 cycles while in_valid stays high -> in_ready = 0, and out_data is unchanged throughout;
  - release out_ready -> no result is lost or duplicated.
- Flush: with 3 operations in flight, pulse flush for 1 cycle -> out_valid stays 0 for those 3 operations, and an operation issued after the flush returns normally 4 cycles later.
- Reset mid-operation: assert rst_n low with the pipe full -> out_valid, out_data and out_zero are 0 immediately, without waiting for a clock edge, and in_ready = 1 after release.

Source files
------------

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL/SRA/ROR/SRL over log2(WIDTH) registered stages,
// MSB of the shift amount first, with valid/ready handshakes and a registered zero flag.
module pipelined_shifter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRA = 2'b01,
    MODE_ROR = 2'b10,
    MODE_SRL = 2'b11
  } mode_e;

  logic [WIDTH-1:0] st_data  [SHW];
  logic [SHW-1:0]   st_shamt [SHW];
  mode_e            st_mode  [SHW];
  logic [SHW-1:0]   st_valid;
  logic             zero_q;

  logic [WIDTH-1:0] nxt_data [SHW];
  logic             adv_c;
  logic             accept_c;

  // Shift by a fixed amount (1..WIDTH-1); SRA keeps the MSB, which is always the original sign.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input mode_e m,
                                                input int unsigned amt);
    logic [WIDTH-1:0] r;
    r = d;
    case (m)
      MODE_SLL: r = d << amt;
      MODE_SRL: r = d >> amt;
      MODE_SRA: r = WIDTH'($signed(d) >>> amt);
      default:  r = (d >> amt) | (d << (WIDTH - amt));
    endcase
    return r;
  endfunction

  // Stage k conditionally applies the shift for bit (SHW-1-k) of the amount.
  function automatic logic [WIDTH-1:0] stage_fn(input logic [WIDTH-1:0] d,
                                                input mode_e m,
                                                input logic [SHW-1:0] sh,
                                                input int unsigned k);
    logic [WIDTH-1:0] r;
    r = d;
    if (sh[SHW-1-k]) r = shift_by(d, m, 32'(1) << (SHW - 1 - k));
    return r;
  endfunction

  assign adv_c    = !st_valid[SHW-1] || out_ready;
  assign in_ready = adv_c && !flush;
  assign accept_c = in_valid && in_ready;

  always_comb begin
    nxt_data[0] = stage_fn(in_data, mode_e'(in_mode), in_shamt, 0);
    for (int unsigned k = 1; k < SHW; k++) begin
      nxt_data[k] = stage_fn(st_data[k-1], st_mode[k-1], st_shamt[k-1], k);
    end
  end

  // Whole pipe advances together; flush only kills valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      zero_q   <= 1'b0;
      for (int unsigned k = 0; k < SHW; k++) begin
        st_data[k]  <= '0;
        st_shamt[k] <= '0;
        st_mode[k]  <= MODE_SLL;
      end
    end else begin
      if (flush) begin
        st_valid <= '0;
      end else if (adv_c) begin
        st_valid[0] <= accept_c;
        for (int unsigned k = 1; k < SHW; k++) st_valid[k] <= st_valid[k-1];
      end
      if (adv_c) begin
        st_data[0]  <= nxt_data[0];
        st_shamt[0] <= in_shamt;
        st_mode[0]  <= mode_e'(in_mode);
        for (int unsigned k = 1; k < SHW; k++) begin
          st_data[k]  <= nxt_data[k];
          st_shamt[k] <= st_shamt[k-1];
          st_mode[k]  <= st_mode[k-1];
        end
        zero_q <= (nxt_data[SHW-1] == '0);
      end
    end
  end

  assign out_valid = st_valid[SHW-1];
  assign out_data  = st_data[SHW-1];
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: bit-level reference model, in-order
// scoreboard, directed cases, backpressure, flush, mid-run reset and random traffic.
module tb_pipelined_shifter;

  localparam int unsigned W   = 16;
  localparam int unsigned SHW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SHW-1:0] in_shamt;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_zero;

  pipelined_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         z;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  bit           strict_lat = 1'b1;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] last_pop = '0;

  // Reference: each output bit picked straight from the operand by the mode's rule.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int sh,
                                             input logic [1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(W); i++) begin
      case (m)
        2'b00: r[i] = (i >= sh) ? d[i-sh] : 1'b0;
        2'b11: r[i] = (i + sh < int'(W)) ? d[i+sh] : 1'b0;
        2'b01: r[i] = (i + sh < int'(W)) ? d[i+sh] : d[W-1];
        default: r[i] = d[(i + sh) % int'(W)];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive, then check every output against the scoreboard.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic [SHW-1:0] sh,
                       input logic [1:0] m, input logic ordy, input logic fl);
    logic [W-1:0] e;
    int lat;
    @(negedge clk);
    in_valid = v; in_data = d; in_shamt = sh; in_mode = m;
    out_ready = ordy; flush = fl;
    #1;
    chk(in_ready == ((!out_valid || ordy) && !fl), "in_ready", 32'(in_ready),
        32'((!out_valid || ordy) && !fl));
    if (prev_stall) begin
      chk(out_valid == 1'b1, "hold_valid", 32'(out_valid), 32'd1);
      chk(out_data == prev_data, "hold_data", 32'(out_data), 32'(prev_data));
    end
    if (out_valid && q.size() == 0 && !fl)
      chk(1'b0, "spurious_out", 32'(out_data), 32'd0);
    if (fl) begin
      q.delete();
    end else begin
      if (out_valid && q.size() > 0) begin
        chk(out_data == q[0].d, "out_data", 32'(out_data), 32'(q[0].d));
        chk(out_zero == q[0].z, "out_zero", 32'(out_zero), 32'(q[0].z));
        if (ordy) begin
          lat = cyc - q[0].acc;
          if (strict_lat) chk(lat == int'(SHW), "latency", 32'(lat), 32'(SHW));
          else            chk(lat >= int'(SHW), "latency_min", 32'(lat), 32'(SHW));
          last_pop = out_data;
          void'(q.pop_front());
        end
      end
      if (v && in_ready) begin
        e = ref_shift(d, int'(sh), m);
        q.push_back('{d: e, z: (e == '0), acc: cyc});
      end
    end
    prev_stall = out_valid && !ordy && !fl;
    prev_data  = out_data;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() > 0 && n < budget) begin
      cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
      n++;
    end
    chk(q.size() == 0, "drain", 32'(q.size()), 32'd0);
  endtask

  task automatic single(input logic [W-1:0] d, input logic [SHW-1:0] sh, input logic [1:0] m,
                        input logic [W-1:0] lit, input string name);
    chk(ref_shift(d, int'(sh), m) == lit, {name, "_model"}, 32'(ref_shift(d, int'(sh), m)),
        32'(lit));
    cycle(1'b1, d, sh, m, 1'b1, 1'b0);
    drain(10);
    chk(last_pop == lit, {name, "_dut"}, 32'(last_pop), 32'(lit));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_shamt = '0; in_mode = 2'b00; out_ready = 1'b1;
    #1;
    chk(out_valid == 1'b0, "rst_valid", 32'(out_valid), 32'd0);
    chk(out_data == '0, "rst_data", 32'(out_data), 32'd0);
    chk(out_zero == 1'b0, "rst_zero", 32'(out_zero), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk(in_ready == 1'b1, "ready_after_rst", 32'(in_ready), 32'd1);

    // Directed modes, zero and identity
    single(16'h0001, 4'd15, 2'b00, 16'h8000, "sll15");
    single(16'h8000, 4'd15, 2'b01, 16'hFFFF, "sra15");
    single(16'h8000, 4'd4,  2'b11, 16'h0800, "srl4");
    single(16'h0001, 4'd1,  2'b10, 16'h8000, "ror1");
    single(16'h8000, 4'd1,  2'b00, 16'h0000, "sll_zero");
    single(16'h1234, 4'd0,  2'b01, 16'h1234, "sra_ident");
    single(16'h00F1, 4'd4,  2'b10, 16'h100F, "ror4");

    // Streaming: 8 back-to-back random operations
    for (int i = 0; i < 8; i++)
      cycle(1'b1, W'($urandom), SHW'($urandom), 2'($urandom), 1'b1, 1'b0);
    drain(10);

    // Backpressure: 5 stalled cycles with in_valid held high
    for (int i = 0; i < 4; i++)
      cycle(1'b1, W'($urandom), SHW'($urandom), 2'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, W'($urandom), SHW'($urandom), 2'($urandom), 1'b0, 1'b0);
      chk(in_ready == 1'b0, "bp_in_ready", 32'(in_ready), 32'd0);
    end
    strict_lat = 1'b0;
    drain(12);
    strict_lat = 1'b1;

    // Flush with 3 operations in flight
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 16'hFFFF, SHW'(i), 2'b10, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
      chk(out_valid == 1'b0, "flush_quiet", 32'(out_valid), 32'd0);
    end
    single(16'hA5A5, 4'd8, 2'b11, 16'h00A5, "post_flush");

    // Reset with the pipe full and stalled
    strict_lat = 1'b0;
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 16'h8001 | W'(i), 4'd3, 2'b01, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk(out_valid == 1'b0, "mid_rst_valid", 32'(out_valid), 32'd0);
    chk(out_data == '0, "mid_rst_data", 32'(out_data), 32'd0);
    chk(out_zero == 1'b0, "mid_rst_zero", 32'(out_zero), 32'd0);
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk(in_ready == 1'b1, "mid_rst_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b0);

    // Random traffic with random backpressure and rare flushes
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 3) != 0), W'($urandom), SHW'($urandom), 2'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
